// File: rtl/dti_arb_pkg.sv
// Shared arbitration helpers: index width and a round-robin pick function.
// Combinational only, no backpressure.
package dti_arb_pkg;

    localparam int RR_MAXN = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of vld[0 +: n], scanning from ptr upward with wrap.
    function automatic rr_pick_t rr_pick(input logic [RR_MAXN-1:0] vld, input int ptr, input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < RR_MAXN; k++) begin
            if (k < n) begin
                j = (ptr + k) % n;
                if (!r.found && vld[j]) begin
                    r.found = 1'b1;
                    r.idx   = 5'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dti_s_if.sv
// DTI stream bundle: valid/ready handshake with a data word.
// Beat transfers when valid and ready are both high; valid/data hold until then.
interface dti_s_if #(parameter int DW = 8);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: rotate by ptr, pick lowest request, unrotate.
// Latency 0 (combinational); no backpressure.
module rr_prio_enc
    import dti_arb_pkg::*;
#(
    parameter int SIZE = 2,
    localparam int IW  = idx_w(SIZE)
) (
    input  logic [SIZE-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   idx_o,
    output logic            found_o
);

    logic [SIZE-1:0] rot;
    logic [IW-1:0]   off;
    int              j;
    int              sum;

    always_comb begin
        rot = '0;
        j   = 0;
        for (int k = 0; k < SIZE; k++) begin
            j = int'(ptr_i) + k;
            if (j >= SIZE) j = j - SIZE;
            rot[k] = req_i[j];
        end

        off = '0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        found_o = |rot;

        sum = int'(ptr_i) + int'(off);
        if (sum >= SIZE) sum = sum - SIZE;
        idx_o = IW'(sum);
    end

endmodule

// File: rtl/dti_rr_arb.sv
// Round-robin merge of SIZE DTI streams onto one; DTI_ARB_PKT_LOCK_EN adds packet lock.
// Latency 0 (valid/data/ready combinational); a stalled grant is held until accepted.
module dti_rr_arb
    import dti_arb_pkg::*;
#(
    parameter int SIZE    = 2,
    parameter int EOT_BIT = 0,
    parameter int DW      = 8,
    localparam int IW     = idx_w(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    dti_s_if.consumer       din [SIZE],
    dti_s_if.producer       dout,
    output logic [IW-1:0]   dout_sel
);

`ifdef DTI_ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic [SIZE-1:0] vld_vec;
    logic [SIZE-1:0] rdy_vec;
    logic [DW-1:0]   dat_arr [SIZE];

    for (genvar g = 0; g < SIZE; g++) begin : g_port
        assign vld_vec[g]   = din[g].valid;
        assign dat_arr[g]   = din[g].data;
        assign din[g].ready = rdy_vec[g];
    end

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic          held_q, held_d;

    logic [IW-1:0] pick_idx;
    logic          pick_found;

    rr_prio_enc #(.SIZE(SIZE)) u_enc (
        .req_i   (vld_vec),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    logic [IW-1:0] cand;
    logic          out_vld;
    logic          eot;

    always_comb begin
        cand     = held_q ? gnt_q : pick_idx;
        out_vld  = 1'b0;
        rdy_vec  = '0;
        dout_sel = '0;
        if (!rst && (held_q || pick_found)) begin
            out_vld       = vld_vec[cand];
            dout_sel      = cand;
            rdy_vec[cand] = dout.ready;
        end
        dout.valid = out_vld;
        dout.data  = dat_arr[cand];
        eot        = dat_arr[cand][EOT_BIT];
    end

    // A stall pins the grant so valid/data stay stable; a non-EOT beat pins it under lock.
    always_comb begin
        ptr_d  = ptr_q;
        held_d = held_q;
        gnt_d  = gnt_q;
        if (out_vld && !dout.ready) begin
            held_d = 1'b1;
            gnt_d  = cand;
        end else if (out_vld && dout.ready) begin
            if (LOCK_EN && !eot) begin
                held_d = 1'b1;
                gnt_d  = cand;
            end else begin
                held_d = 1'b0;
                ptr_d  = (int'(cand) == SIZE - 1) ? '0 : cand + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            held_q <= 1'b0;
            gnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            held_q <= held_d;
            gnt_q  <= gnt_d;
        end
    end

endmodule
